ct_idu_rf_pipe2_launch: RTL and testbench

RF-stage launch pipeline for pipe2, the branch/jump unit (BJU). It takes pipe2 instructions from the issue stage into an RF entry register and drives the registered opcode to the pipe2 decoder. It then captures the returned func/offset, together with the instruction's IID and operands, into an EX1 launch register facing the BJU. The block handles the issue handshake, BJU back-pressure, flush, and a saturating stall performance counter.

---
 rtl/ct_idu_rf_pipe2_launch.sv | 119 +++++++++++
 tb/tb_ct_idu_rf_pipe2_launch.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_idu_rf_pipe2_launch.sv
// Pipe2 (BJU) RF-stage launch: issue -> RF entry -> decoder -> EX1 launch register, plus stall counter.
// Latency: issue accepted at edge N is visible on idu_bju_ex1_sel after edge N+1; one instruction per cycle.
// Backpressure: bju_idu_ex1_stall freezes EX1; RF holds one instruction and drops ready while EX1 is stalled.
module ct_idu_rf_pipe2_launch #(
    parameter int IID_W  = 7,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              rtu_yy_xx_flush,
    input  logic              is_rf_pipe2_inst_vld,
    input  logic [31:0]       is_rf_pipe2_opcode,
    input  logic [IID_W-1:0]  is_rf_pipe2_iid,
    input  logic [DATA_W-1:0] is_rf_pipe2_src0_data,
    input  logic [DATA_W-1:0] is_rf_pipe2_src1_data,
    output logic              rf_is_pipe2_ready,
    output logic [31:0]       pipe2_decd_opcode,
    input  logic [7:0]        pipe2_decd_func,
    input  logic [20:0]       pipe2_decd_offset,
    input  logic              bju_idu_ex1_stall,
    output logic              idu_bju_ex1_sel,
    output logic [7:0]        idu_bju_ex1_func,
    output logic [20:0]       idu_bju_ex1_offset,
    output logic [IID_W-1:0]  idu_bju_ex1_iid,
    output logic [DATA_W-1:0] idu_bju_ex1_src0,
    output logic [DATA_W-1:0] idu_bju_ex1_src1,
    output logic              idu_bju_ex1_inst_err,
    input  logic              hpcp_pipe2_cnt_clr,
    output logic [CNT_W-1:0]  idu_hpcp_pipe2_stall_cnt
);

    logic              rf_vld;
    logic              ex1_vld;
    logic [31:0]       rf_opcode;
    logic [IID_W-1:0]  rf_iid;
    logic [DATA_W-1:0] rf_src0;
    logic [DATA_W-1:0] rf_src1;
    logic [CNT_W-1:0]  stall_cnt;
    logic              ex1_adv;
    logic              accept;
    logic              launch;

    assign ex1_adv           = !ex1_vld || !bju_idu_ex1_stall;
    assign rf_is_pipe2_ready = !rf_vld || ex1_adv;
    assign accept            = is_rf_pipe2_inst_vld && rf_is_pipe2_ready && !rtu_yy_xx_flush;
    assign launch            = rf_vld && ex1_adv && !rtu_yy_xx_flush;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rf_vld  <= 1'b0;
            ex1_vld <= 1'b0;
        end else begin
            // Accept outranks launch so a back-to-back stream keeps RF occupied.
            if (rtu_yy_xx_flush)
                rf_vld <= 1'b0;
            else if (accept)
                rf_vld <= 1'b1;
            else if (launch)
                rf_vld <= 1'b0;

            if (rtu_yy_xx_flush)
                ex1_vld <= 1'b0;
            else if (launch)
                ex1_vld <= 1'b1;
            else
                ex1_vld <= ex1_vld && bju_idu_ex1_stall;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rf_opcode <= '0;
            rf_iid    <= '0;
            rf_src0   <= '0;
            rf_src1   <= '0;
        end else if (accept) begin
            rf_opcode <= is_rf_pipe2_opcode;
            rf_iid    <= is_rf_pipe2_iid;
            rf_src0   <= is_rf_pipe2_src0_data;
            rf_src1   <= is_rf_pipe2_src1_data;
        end
    end

    assign pipe2_decd_opcode = rf_opcode;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            idu_bju_ex1_func     <= '0;
            idu_bju_ex1_offset   <= '0;
            idu_bju_ex1_iid      <= '0;
            idu_bju_ex1_src0     <= '0;
            idu_bju_ex1_src1     <= '0;
            idu_bju_ex1_inst_err <= 1'b0;
        end else if (launch) begin
            idu_bju_ex1_func     <= pipe2_decd_func;
            idu_bju_ex1_offset   <= pipe2_decd_offset;
            idu_bju_ex1_iid      <= rf_iid;
            idu_bju_ex1_src0     <= rf_src0;
            idu_bju_ex1_src1     <= rf_src1;
            idu_bju_ex1_inst_err <= (pipe2_decd_func == 8'h00);
        end
    end

    assign idu_bju_ex1_sel = ex1_vld;

    // Clear wins over increment; the count sticks at all-ones and survives flush.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            stall_cnt <= '0;
        else if (hpcp_pipe2_cnt_clr)
            stall_cnt <= '0;
        else if (ex1_vld && bju_idu_ex1_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign idu_hpcp_pipe2_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_ct_idu_rf_pipe2_launch.sv
// Bench for the pipe2 RF launch stage: a queue-based transaction model plus a small RISC-V branch decoder.
module tb_ct_idu_rf_pipe2_launch;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        rtu_yy_xx_flush;
    logic        is_rf_pipe2_inst_vld;
    logic [31:0] is_rf_pipe2_opcode;
    logic [6:0]  is_rf_pipe2_iid;
    logic [63:0] is_rf_pipe2_src0_data;
    logic [63:0] is_rf_pipe2_src1_data;
    logic        rf_is_pipe2_ready;
    logic [31:0] pipe2_decd_opcode;
    logic [7:0]  pipe2_decd_func;
    logic [20:0] pipe2_decd_offset;
    logic        bju_idu_ex1_stall;
    logic        idu_bju_ex1_sel;
    logic [7:0]  idu_bju_ex1_func;
    logic [20:0] idu_bju_ex1_offset;
    logic [6:0]  idu_bju_ex1_iid;
    logic [63:0] idu_bju_ex1_src0;
    logic [63:0] idu_bju_ex1_src1;
    logic        idu_bju_ex1_inst_err;
    logic        hpcp_pipe2_cnt_clr;
    logic [7:0]  idu_hpcp_pipe2_stall_cnt;

    int asserts = 0;
    int fails   = 0;

    ct_idu_rf_pipe2_launch #(.IID_W(7), .DATA_W(64), .CNT_W(8)) dut (
        .forever_cpuclk          (forever_cpuclk),
        .cpurst_b                (cpurst_b),
        .rtu_yy_xx_flush         (rtu_yy_xx_flush),
        .is_rf_pipe2_inst_vld    (is_rf_pipe2_inst_vld),
        .is_rf_pipe2_opcode      (is_rf_pipe2_opcode),
        .is_rf_pipe2_iid         (is_rf_pipe2_iid),
        .is_rf_pipe2_src0_data   (is_rf_pipe2_src0_data),
        .is_rf_pipe2_src1_data   (is_rf_pipe2_src1_data),
        .rf_is_pipe2_ready       (rf_is_pipe2_ready),
        .pipe2_decd_opcode       (pipe2_decd_opcode),
        .pipe2_decd_func         (pipe2_decd_func),
        .pipe2_decd_offset       (pipe2_decd_offset),
        .bju_idu_ex1_stall       (bju_idu_ex1_stall),
        .idu_bju_ex1_sel         (idu_bju_ex1_sel),
        .idu_bju_ex1_func        (idu_bju_ex1_func),
        .idu_bju_ex1_offset      (idu_bju_ex1_offset),
        .idu_bju_ex1_iid         (idu_bju_ex1_iid),
        .idu_bju_ex1_src0        (idu_bju_ex1_src0),
        .idu_bju_ex1_src1        (idu_bju_ex1_src1),
        .idu_bju_ex1_inst_err    (idu_bju_ex1_inst_err),
        .hpcp_pipe2_cnt_clr      (hpcp_pipe2_cnt_clr),
        .idu_hpcp_pipe2_stall_cnt(idu_hpcp_pipe2_stall_cnt)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Decoder stand-in: returns {func, offset}. jal=0x40, beq-class=0x20, jalr=0x10, anything else 0.
    function automatic logic [28:0] decode(input logic [31:0] op);
        logic [20:0] off;
        case (op[6:0])
            7'h6F: begin
                off = {op[31], op[19:12], op[20], op[30:21], 1'b0};
                return {8'h40, off};
            end
            7'h63: begin
                off = {{8{op[31]}}, op[31], op[7], op[30:25], op[11:8], 1'b0};
                return {8'h20, off};
            end
            7'h67: begin
                off = {{9{op[31]}}, op[31:20]};
                return {8'h10, off};
            end
            default: return 29'd0;
        endcase
    endfunction

    always_comb {pipe2_decd_func, pipe2_decd_offset} = decode(pipe2_decd_opcode);

    typedef struct packed {
        logic [31:0] op;
        logic [6:0]  iid;
        logic [63:0] s0;
        logic [63:0] s1;
    } ins_t;

    // The model sees the stage pair as two single-slot queues; the EX1 slot keeps the decoded result.
    ins_t        rf_q[$];
    ins_t        ex_q[$];
    logic [28:0] ex_dec;
    int          m_cnt;

    function automatic bit m_ready();
        return rf_q.size() == 0 || ex_q.size() == 0 || !bju_idu_ex1_stall;
    endfunction

    function automatic bit m_sel();
        return ex_q.size() != 0;
    endfunction

    function automatic logic [164:0] m_ex1();
        logic [6:0]  id;
        logic [63:0] a;
        logic [63:0] b;
        id = ex_q[0].iid;
        a  = ex_q[0].s0;
        b  = ex_q[0].s1;
        return {id, ex_dec[28:21], ex_dec[20:0], a, b, (ex_dec[28:21] == 8'h00)};
    endfunction

    task automatic model_reset();
        rf_q.delete();
        ex_q.delete();
        ex_dec = '0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit   ex_free;
        bit   take;
        ins_t nin;
        ex_free = ex_q.size() == 0 || !bju_idu_ex1_stall;
        take    = is_rf_pipe2_inst_vld && m_ready() && !rtu_yy_xx_flush;
        nin     = '{is_rf_pipe2_opcode, is_rf_pipe2_iid, is_rf_pipe2_src0_data, is_rf_pipe2_src1_data};
        if (hpcp_pipe2_cnt_clr)
            m_cnt = 0;
        else if (ex_q.size() != 0 && bju_idu_ex1_stall && m_cnt < 255)
            m_cnt = m_cnt + 1;
        if (rtu_yy_xx_flush) begin
            rf_q.delete();
            ex_q.delete();
        end else begin
            if (ex_free) begin
                ex_q.delete();
                if (rf_q.size() != 0) begin
                    ex_dec = decode(rf_q[0].op);
                    ex_q.push_back(rf_q.pop_front());
                end
            end
            if (take) rf_q.push_back(nin);
        end
    endtask

    task automatic tick();
        @(posedge forever_cpuclk);
        model_step();
        @(negedge forever_cpuclk);
    endtask

    task automatic drive(input bit v, input logic [31:0] op, input logic [6:0] id,
                         input bit st, input bit fl, input bit cl);
        is_rf_pipe2_inst_vld  = v;
        is_rf_pipe2_opcode    = op;
        is_rf_pipe2_iid       = id;
        is_rf_pipe2_src0_data = {$urandom, $urandom};
        is_rf_pipe2_src1_data = {$urandom, $urandom};
        bju_idu_ex1_stall     = st;
        rtu_yy_xx_flush       = fl;
        hpcp_pipe2_cnt_clr    = cl;
    endtask

    task automatic drain();
        drive(0, 32'h0, 7'h0, 0, 0, 1);
        tick();
        tick();
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        model_reset();
        #12;
        asserts++;
        if ({idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid,
             idu_bju_ex1_inst_err, idu_hpcp_pipe2_stall_cnt, pipe2_decd_opcode} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got sel=%0b func=%0h off=%0h iid=%0h err=%0b cnt=%0d op=%0h, required all 0",
                     idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid,
                     idu_bju_ex1_inst_err, idu_hpcp_pipe2_stall_cnt, pipe2_decd_opcode);
        end
        asserts++;
        if ({idu_bju_ex1_src0, idu_bju_ex1_src1} !== '0 || rf_is_pipe2_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_src_ready: got src0=%0h src1=%0h ready=%0b, required 0 0 1",
                     idu_bju_ex1_src0, idu_bju_ex1_src1, rf_is_pipe2_ready);
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h0080006F, 7'd10, 0, 0, 0);
        tick();
        drive(1, 32'h00208463, 7'd11, 0, 0, 0);
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        #1;
        asserts++;
        if ({idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid} !== {1'b1, 8'h40, 21'd8, 7'd10}) begin
            fails++;
            $display("FAIL b2b_jal: got sel=%0b func=%0h off=%0h iid=%0d, required 1 40 8 10",
                     idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid);
        end
        tick();
        asserts++;
        if ({idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid} !== {1'b1, 8'h20, 21'd8, 7'd11}) begin
            fails++;
            $display("FAIL b2b_beq: got sel=%0b func=%0h off=%0h iid=%0d, required 1 20 8 11",
                     idu_bju_ex1_sel, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_iid);
        end
        asserts++;
        if (idu_bju_ex1_src0 !== ex_q[0].s0 || idu_bju_ex1_src1 !== ex_q[0].s1) begin
            fails++;
            $display("FAIL b2b_src: got %0h %0h, required %0h %0h",
                     idu_bju_ex1_src0, idu_bju_ex1_src1, ex_q[0].s0, ex_q[0].s1);
        end
        tick();
        asserts++;
        if (idu_bju_ex1_sel !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty: got sel=%0b, required 0", idu_bju_ex1_sel);
        end
    endtask

    task automatic test_stall();
        drain();
        drive(1, 32'h0080006F, 7'd20, 0, 0, 0);
        tick();
        drive(1, 32'h00208463, 7'd21, 0, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h00000067, 7'd22, 1, 0, 0);
            #1;
            asserts++;
            if (rf_is_pipe2_ready !== 1'b0 || idu_bju_ex1_sel !== 1'b1 || idu_bju_ex1_iid !== 7'd20
                || idu_bju_ex1_func !== 8'h40) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got ready=%0b sel=%0b iid=%0d func=%0h, required 0 1 20 40",
                         c, rf_is_pipe2_ready, idu_bju_ex1_sel, idu_bju_ex1_iid, idu_bju_ex1_func);
            end
            tick();
        end
        drive(1, 32'h00000067, 7'd22, 0, 0, 0);
        #1;
        asserts++;
        if (rf_is_pipe2_ready !== 1'b1 || idu_hpcp_pipe2_stall_cnt !== 8'd3) begin
            fails++;
            $display("FAIL stall_release: got ready=%0b cnt=%0d, required 1 3",
                     rf_is_pipe2_ready, idu_hpcp_pipe2_stall_cnt);
        end
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        #1;
        asserts++;
        if (idu_bju_ex1_sel !== 1'b1 || idu_bju_ex1_iid !== 7'd21 || idu_hpcp_pipe2_stall_cnt !== 8'd3) begin
            fails++;
            $display("FAIL stall_next: got sel=%0b iid=%0d cnt=%0d, required 1 21 3",
                     idu_bju_ex1_sel, idu_bju_ex1_iid, idu_hpcp_pipe2_stall_cnt);
        end
        tick();
        asserts++;
        if (idu_bju_ex1_sel !== 1'b1 || idu_bju_ex1_iid !== 7'd22 || idu_bju_ex1_func !== 8'h10) begin
            fails++;
            $display("FAIL stall_third: got sel=%0b iid=%0d func=%0h, required 1 22 10",
                     idu_bju_ex1_sel, idu_bju_ex1_iid, idu_bju_ex1_func);
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1, 32'h0080006F, 7'd30, 0, 0, 0);
        tick();
        drive(1, 32'h00208463, 7'd31, 0, 1, 0);
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            asserts++;
            if (idu_bju_ex1_sel !== 1'b0 || rf_is_pipe2_ready !== 1'b1) begin
                fails++;
                $display("FAIL flush_clear[%0d]: got sel=%0b ready=%0b iid=%0d, required 0 1",
                         c, idu_bju_ex1_sel, rf_is_pipe2_ready, idu_bju_ex1_iid);
            end
            tick();
        end
    endtask

    task automatic test_inst_err();
        drain();
        drive(1, 32'h002081B3, 7'd40, 0, 0, 0);
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        tick();
        asserts++;
        if ({idu_bju_ex1_sel, idu_bju_ex1_inst_err, idu_bju_ex1_func, idu_bju_ex1_iid} !== {1'b1, 1'b1, 8'h00, 7'd40}) begin
            fails++;
            $display("FAIL inst_err: got sel=%0b err=%0b func=%0h iid=%0d, required 1 1 0 40",
                     idu_bju_ex1_sel, idu_bju_ex1_inst_err, idu_bju_ex1_func, idu_bju_ex1_iid);
        end
        tick();
    endtask

    task automatic test_saturation();
        drain();
        drive(1, 32'h0080006F, 7'd45, 0, 0, 0);
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        tick();
        drive(0, 32'h0, 7'h0, 1, 0, 0);
        for (int c = 0; c < 300; c++) tick();
        asserts++;
        if (idu_hpcp_pipe2_stall_cnt !== 8'd255 || m_cnt != 255) begin
            fails++;
            $display("FAIL cnt_saturate: got %0d, required 255", idu_hpcp_pipe2_stall_cnt);
        end
        drive(0, 32'h0, 7'h0, 1, 0, 1);
        tick();
        asserts++;
        if (idu_hpcp_pipe2_stall_cnt !== 8'd0) begin
            fails++;
            $display("FAIL cnt_clear: got %0d, required 0", idu_hpcp_pipe2_stall_cnt);
        end
        drive(0, 32'h0, 7'h0, 1, 1, 0);
        tick();
        asserts++;
        if (idu_hpcp_pipe2_stall_cnt !== 8'd1 || idu_bju_ex1_sel !== 1'b0) begin
            fails++;
            $display("FAIL cnt_after_clear: got cnt=%0d sel=%0b, required 1 0",
                     idu_hpcp_pipe2_stall_cnt, idu_bju_ex1_sel);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] op;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(3))
                0: op = {$urandom_range(32'hFFFFFFFF)} & 32'hFFFFFF80 | 32'h6F;
                1: op = {$urandom_range(32'hFFFFFFFF)} & 32'hFFFFFF80 | 32'h63;
                2: op = {$urandom_range(32'hFFFFFFFF)} & 32'hFFFFFF80 | 32'h67;
                default: op = 32'h002081B3;
            endcase
            drive($urandom_range(9) < 7, op, 7'($urandom_range(127)), $urandom_range(9) < 3,
                  $urandom_range(49) == 0, $urandom_range(59) == 0);
            #1;
            asserts++;
            if (rf_is_pipe2_ready !== m_ready() || idu_bju_ex1_sel !== m_sel()) begin
                fails++;
                $display("FAIL rand_ctl[%0d]: got ready=%0b sel=%0b, required %0b %0b",
                         c, rf_is_pipe2_ready, idu_bju_ex1_sel, m_ready(), m_sel());
            end
            if (m_sel()) begin
                asserts++;
                if ({idu_bju_ex1_iid, idu_bju_ex1_func, idu_bju_ex1_offset, idu_bju_ex1_src0,
                     idu_bju_ex1_src1, idu_bju_ex1_inst_err} !== m_ex1()) begin
                    fails++;
                    $display("FAIL rand_ex1[%0d]: got iid=%0d func=%0h off=%0h err=%0b, required %0h",
                             c, idu_bju_ex1_iid, idu_bju_ex1_func, idu_bju_ex1_offset,
                             idu_bju_ex1_inst_err, m_ex1());
                end
            end
            asserts++;
            if (idu_hpcp_pipe2_stall_cnt !== 8'(m_cnt)) begin
                fails++;
                $display("FAIL rand_cnt[%0d]: got %0d, required %0d", c, idu_hpcp_pipe2_stall_cnt, m_cnt);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drain();
        drive(1, 32'h0080006F, 7'd50, 0, 0, 0);
        tick();
        drive(1, 32'h00208463, 7'd51, 1, 0, 0);
        tick();
        tick();
        #2;
        cpurst_b = 1'b0;
        model_reset();
        #1;
        asserts++;
        if (idu_bju_ex1_sel !== 1'b0 || idu_hpcp_pipe2_stall_cnt !== 8'd0 || rf_is_pipe2_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got sel=%0b cnt=%0d ready=%0b, required 0 0 1",
                     idu_bju_ex1_sel, idu_hpcp_pipe2_stall_cnt, rf_is_pipe2_ready);
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        drive(1, 32'h00208463, 7'd55, 0, 0, 0);
        tick();
        drive(0, 32'h0, 7'h0, 0, 0, 0);
        #1;
        asserts++;
        if (idu_bju_ex1_sel !== 1'b0) begin
            fails++;
            $display("FAIL reset_relaunch_early: got sel=%0b, required 0", idu_bju_ex1_sel);
        end
        tick();
        asserts++;
        if (idu_bju_ex1_sel !== 1'b1 || idu_bju_ex1_iid !== 7'd55 || idu_bju_ex1_func !== 8'h20) begin
            fails++;
            $display("FAIL reset_relaunch: got sel=%0b iid=%0d func=%0h, required 1 55 20",
                     idu_bju_ex1_sel, idu_bju_ex1_iid, idu_bju_ex1_func);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_inst_err();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
